// File: rtl/axi_lite_master_ctrl.sv
// Single-outstanding AXI-Lite initiator: one valid/ready command in, one AXI-Lite write or read out, one response back.
// Latency: command accept at cycle 0, AW/W or AR at cycle 1, B/R at cycle 2, rsp_valid at cycle 3 (zero-wait slave).
// Backpressure: cmd_ready is high only in IDLE; every AXI valid and rsp_valid holds until its ready, and a response stalls the next command.
module axi_lite_master_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    // host command side
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,

    // host response side
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,

    // AXI-Lite write address channel
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,

    // AXI-Lite write data channel
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,

    // AXI-Lite write response channel
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,

    // AXI-Lite read address channel
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    // AXI-Lite read data channel
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t                state;
    state_t                state_nxt;

    // Latched command; the same address register feeds both AW and AR.
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  write_q;

    // Registered AW/W valids, each cleared independently by its own handshake.
    logic                  aw_pend;
    logic                  w_pend;

    // Captured response fields, held stable while rsp_valid is up.
    logic [DATA_W-1:0]     rdata_q;
    logic [1:0]            resp_q;

    logic                  accept;
    logic                  aw_done;
    logic                  w_done;

    assign accept  = (state == IDLE) && cmd_valid;
    // A channel counts as done once its valid has dropped or its handshake happens this cycle.
    assign aw_done = !aw_pend || m_axi_awready;
    assign w_done  = !w_pend  || m_axi_wready;

    // State register; reset aborts any in-flight transaction without draining it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and the state-derived handshake outputs.
    always_comb begin
        state_nxt     = state;
        cmd_ready     = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        rsp_valid     = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = cmd_write ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                if (aw_done && w_done) begin
                    state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    state_nxt = RSP;
                end
            end
            RD_REQ: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_nxt = RD_RESP;
                end
            end
            RD_RESP: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    state_nxt = RSP;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Command latch; payload stays frozen for the whole transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else if (accept) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            write_q <= cmd_write;
        end
    end

    // AW/W valids rise together after a write is accepted and fall on their own handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
        end else if (accept) begin
            aw_pend <= cmd_write;
            w_pend  <= cmd_write;
        end else if (state == WR_REQ) begin
            if (m_axi_awready) begin
                aw_pend <= 1'b0;
            end
            if (m_axi_wready) begin
                w_pend <= 1'b0;
            end
        end
    end

    // Response capture: B gives resp with zero data, R gives resp plus data; both pass through unmodified.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            resp_q  <= 2'b00;
        end else if ((state == WR_RESP) && m_axi_bvalid) begin
            rdata_q <= '0;
            resp_q  <= m_axi_bresp;
        end else if ((state == RD_RESP) && m_axi_rvalid) begin
            rdata_q <= m_axi_rdata;
            resp_q  <= m_axi_rresp;
        end
    end

    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_awvalid = aw_pend;
    assign m_axi_wvalid  = w_pend;

    assign rsp_write     = write_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;

endmodule

// File: tb/tb_axi_lite_master_ctrl.sv
// Bench for axi_lite_master_ctrl: directed scenarios plus randomized commands against a delay-configurable slave.
// Latency: expected response timing is computed from the slave's wait states.
// Backpressure: the slave inserts AW/W/B/AR/R wait states; the host side holds rsp_ready low on request.
module tb_axi_lite_master_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    axi_lite_master_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Slave configuration chosen by each test.
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
    logic [31:0] s_rdata = 32'h0;

    // Slave observations.
    logic [31:0] got_awaddr, got_wdata, got_araddr;
    logic [3:0]  got_wstrb;
    int aw_hs_cyc, w_hs_cyc, b_hs_cyc, ar_hs_cyc, r_hs_cyc;
    int aw_high, w_high, rr_high;
    int proto_bad = 0;
    int last_acc  = 0;

    // Slave bookkeeping.
    logic s_aw_pend, s_w_pend, s_ar_pend, s_b_pend, s_r_pend;
    logic aw_done, w_done, ar_done;
    int   aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic p_awv, p_wv, p_arv;
    logic [31:0] p_awaddr, p_wdata, p_araddr;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    // Behavioural AXI-Lite slave, evaluated once per cycle on the falling edge.
    initial begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
        s_aw_pend = 0; s_w_pend = 0; s_ar_pend = 0; s_b_pend = 0; s_r_pend = 0;
        aw_done = 0; w_done = 0; ar_done = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        p_awv = 0; p_wv = 0; p_arv = 0; p_awaddr = 0; p_wdata = 0; p_araddr = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
                m_axi_arready = 0; m_axi_rvalid = 0;
                s_aw_pend = 0; s_w_pend = 0; s_ar_pend = 0; s_b_pend = 0; s_r_pend = 0;
                aw_done = 0; w_done = 0; ar_done = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                p_awv = 0; p_wv = 0; p_arv = 0;
            end else begin
                // A valid seen last cycle without a handshake must still be up with the same payload.
                if (p_awv && !s_aw_pend && (!m_axi_awvalid || m_axi_awaddr !== p_awaddr)) proto_bad++;
                if (p_wv  && !s_w_pend  && (!m_axi_wvalid  || m_axi_wdata  !== p_wdata))  proto_bad++;
                if (p_arv && !s_ar_pend && (!m_axi_arvalid || m_axi_araddr !== p_araddr)) proto_bad++;
                if ((m_axi_awvalid || m_axi_wvalid) && (m_axi_arvalid || m_axi_rready)) proto_bad++;

                if (s_aw_pend) begin m_axi_awready = 0; aw_done = 1; s_aw_pend = 0; end
                if (m_axi_awvalid && !m_axi_awready) begin
                    if (aw_cnt >= aw_dly) begin
                        m_axi_awready = 1; got_awaddr = m_axi_awaddr; aw_hs_cyc = cyc; aw_cnt = 0;
                    end else aw_cnt++;
                end
                s_aw_pend = m_axi_awvalid && m_axi_awready;
                if (m_axi_awvalid) aw_high++;

                if (s_w_pend) begin m_axi_wready = 0; w_done = 1; s_w_pend = 0; end
                if (m_axi_wvalid && !m_axi_wready) begin
                    if (w_cnt >= w_dly) begin
                        m_axi_wready = 1; got_wdata = m_axi_wdata; got_wstrb = m_axi_wstrb;
                        w_hs_cyc = cyc; w_cnt = 0;
                    end else w_cnt++;
                end
                s_w_pend = m_axi_wvalid && m_axi_wready;
                if (m_axi_wvalid) w_high++;

                if (s_ar_pend) begin m_axi_arready = 0; ar_done = 1; s_ar_pend = 0; end
                if (m_axi_arvalid && !m_axi_arready) begin
                    if (ar_cnt >= ar_dly) begin
                        m_axi_arready = 1; got_araddr = m_axi_araddr; ar_hs_cyc = cyc; ar_cnt = 0;
                    end else ar_cnt++;
                end
                s_ar_pend = m_axi_arvalid && m_axi_arready;

                if (s_b_pend) begin m_axi_bvalid = 0; s_b_pend = 0; end
                if (!m_axi_bvalid && aw_done && w_done) begin
                    if (b_cnt >= b_dly) begin
                        m_axi_bvalid = 1; m_axi_bresp = s_bresp; aw_done = 0; w_done = 0; b_cnt = 0;
                    end else b_cnt++;
                end
                s_b_pend = m_axi_bvalid && m_axi_bready;
                if (s_b_pend) b_hs_cyc = cyc;

                if (s_r_pend) begin m_axi_rvalid = 0; s_r_pend = 0; end
                if (!m_axi_rvalid && ar_done) begin
                    if (r_cnt >= r_dly) begin
                        m_axi_rvalid = 1; m_axi_rdata = s_rdata; m_axi_rresp = s_rresp;
                        ar_done = 0; r_cnt = 0;
                    end else r_cnt++;
                end
                s_r_pend = m_axi_rvalid && m_axi_rready;
                if (s_r_pend) r_hs_cyc = cyc;
                if (m_axi_rready) rr_high++;

                p_awv = m_axi_awvalid; p_awaddr = m_axi_awaddr;
                p_wv  = m_axi_wvalid;  p_wdata  = m_axi_wdata;
                p_arv = m_axi_arvalid; p_araddr = m_axi_araddr;
            end
        end
    end

    // Issue one command, wait for its response, optionally hold rsp_ready low for `hold` cycles.
    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input int hold, output logic o_wr, output logic [31:0] o_rdata,
                           output logic [1:0] o_resp, output int o_lat, output int o_unstable,
                           output int o_to);
        int n;
        o_wr = 0; o_rdata = 0; o_resp = 0; o_lat = -1; o_unstable = 0; o_to = 0;
        @(negedge clk);
        aw_high = 0; w_high = 0; rr_high = 0;
        aw_hs_cyc = -100; w_hs_cyc = -100; b_hs_cyc = -100; ar_hs_cyc = -100; r_hs_cyc = -100;
        got_awaddr = 'x; got_wdata = 'x; got_araddr = 'x; got_wstrb = 'x;
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
        n = 0;
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        if (!cmd_ready) begin cmd_valid = 0; o_to = 1; return; end
        last_acc = cyc;
        @(negedge clk);
        cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
        n = 0;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        if (!rsp_valid) begin o_to = 1; return; end
        o_lat = cyc - last_acc; o_wr = rsp_write; o_rdata = rsp_rdata; o_resp = rsp_resp;
        for (int i = 0; i <= hold; i++) begin
            if (rsp_valid !== 1'b1 || rsp_write !== o_wr || rsp_rdata !== o_rdata ||
                rsp_resp !== o_resp || cmd_ready !== 1'b0) o_unstable++;
            if (i == hold) rsp_ready = 1;
            @(negedge clk);
        end
        rsp_ready = 0;
    endtask

    task automatic set_slave(input int a, input int w, input int b, input int ar, input int r);
        aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    task automatic test_reset();
        rst = 1; cmd_valid = 0; rsp_ready = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        repeat (3) @(negedge clk);
        total++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid, cmd_ready} !== 7'b0000001) begin
            bad++; $display("FAIL reset_handshakes got=%b exp=0000001",
                {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid, cmd_ready});
        end
        total++;
        if ({m_axi_awaddr, m_axi_araddr, m_axi_wdata} !== 96'd0) begin
            bad++; $display("FAIL reset_payload got=%h/%h/%h exp=0", m_axi_awaddr, m_axi_araddr, m_axi_wdata);
        end
        total++;
        if ({rsp_write, rsp_rdata, rsp_resp} !== 35'd0) begin
            bad++; $display("FAIL reset_rsp got=%b/%h/%b exp=0", rsp_write, rsp_rdata, rsp_resp);
        end
        total++;
        if (m_axi_wstrb !== 4'hF) begin bad++; $display("FAIL reset_wstrb got=%h exp=f", m_axi_wstrb); end
        rst = 0;
    endtask

    task automatic test_zero_wait_write();
        logic ow; logic [31:0] ord; logic [1:0] ors; int lat, uns, to;
        set_slave(0, 0, 0, 0, 0); s_bresp = 2'b00;
        run_cmd(1'b1, 32'h08, 32'h5, 0, ow, ord, ors, lat, uns, to);
        total++; if (to !== 0) begin bad++; $display("FAIL zw_timeout got=%0d exp=0", to); end
        total++; if (aw_hs_cyc - last_acc !== 1) begin bad++; $display("FAIL zw_aw_cycle got=%0d exp=1", aw_hs_cyc - last_acc); end
        total++; if (w_hs_cyc - last_acc !== 1) begin bad++; $display("FAIL zw_w_cycle got=%0d exp=1", w_hs_cyc - last_acc); end
        total++; if (b_hs_cyc - last_acc !== 2) begin bad++; $display("FAIL zw_b_cycle got=%0d exp=2", b_hs_cyc - last_acc); end
        total++; if (lat !== 3) begin bad++; $display("FAIL zw_rsp_cycle got=%0d exp=3", lat); end
        total++; if ({ow, ors, ord} !== {1'b1, 2'b00, 32'h0}) begin bad++; $display("FAIL zw_rsp got=%b/%b/%h exp=1/00/0", ow, ors, ord); end
        total++; if ({got_awaddr, got_wdata, got_wstrb} !== {32'h8, 32'h5, 4'hF}) begin
            bad++; $display("FAIL zw_payload got=%h/%h/%h exp=8/5/f", got_awaddr, got_wdata, got_wstrb);
        end
    endtask

    task automatic test_aw_stall();
        logic ow; logic [31:0] ord; logic [1:0] ors; int lat, uns, to;
        set_slave(3, 0, 0, 0, 0); s_bresp = 2'b00;
        run_cmd(1'b1, 32'h0C, 32'h1234_5678, 0, ow, ord, ors, lat, uns, to);
        total++; if (to !== 0) begin bad++; $display("FAIL aws_timeout got=%0d exp=0", to); end
        total++; if (w_high !== 1) begin bad++; $display("FAIL aws_wvalid_cycles got=%0d exp=1", w_high); end
        total++; if (aw_high !== 4) begin bad++; $display("FAIL aws_awvalid_cycles got=%0d exp=4", aw_high); end
        total++; if (aw_hs_cyc - last_acc !== 4) begin bad++; $display("FAIL aws_aw_cycle got=%0d exp=4", aw_hs_cyc - last_acc); end
        total++; if (lat !== 6) begin bad++; $display("FAIL aws_rsp_cycle got=%0d exp=6", lat); end
        total++; if (got_awaddr !== 32'h0C) begin bad++; $display("FAIL aws_awaddr got=%h exp=c", got_awaddr); end
        total++; if (proto_bad !== 0) begin bad++; $display("FAIL aws_protocol got=%0d exp=0", proto_bad); end
    endtask

    task automatic test_slverr();
        logic ow; logic [31:0] ord; logic [1:0] ors; int lat, uns, to;
        set_slave(0, 1, 0, 0, 0); s_bresp = 2'b10;
        run_cmd(1'b1, 32'h04, 32'hFFFF_0000, 0, ow, ord, ors, lat, uns, to);
        total++; if ({ow, ors, ord} !== {1'b1, 2'b10, 32'h0}) begin bad++; $display("FAIL slverr_rsp got=%b/%b/%h exp=1/10/0", ow, ors, ord); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL slverr_idle got=%b exp=1", cmd_ready); end
        total++; if (lat !== 4) begin bad++; $display("FAIL slverr_rsp_cycle got=%0d exp=4", lat); end
        s_bresp = 2'b00;
    endtask

    task automatic test_read_delay();
        logic ow; logic [31:0] ord; logic [1:0] ors; int lat, uns, to;
        set_slave(0, 0, 0, 0, 4); s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b00;
        run_cmd(1'b0, 32'h00, 32'h0, 0, ow, ord, ors, lat, uns, to);
        total++; if ({ow, ors, ord} !== {1'b0, 2'b00, 32'hDEAD_BEEF}) begin bad++; $display("FAIL rd_rsp got=%b/%b/%h exp=0/00/deadbeef", ow, ors, ord); end
        total++; if (rr_high !== 5) begin bad++; $display("FAIL rd_rready_cycles got=%0d exp=5", rr_high); end
        total++; if (ar_hs_cyc - last_acc !== 1) begin bad++; $display("FAIL rd_ar_cycle got=%0d exp=1", ar_hs_cyc - last_acc); end
        total++; if (lat !== 7) begin bad++; $display("FAIL rd_rsp_cycle got=%0d exp=7", lat); end
        total++; if (got_araddr !== 32'h0) begin bad++; $display("FAIL rd_araddr got=%h exp=0", got_araddr); end
    endtask

    task automatic test_back_to_back();
        logic ow; logic [31:0] ord; logic [1:0] ors; int lat, uns, to;
        set_slave(0, 0, 0, 0, 0); s_bresp = 2'b01;
        run_cmd(1'b1, 32'h10, 32'hA5A5_0001, 5, ow, ord, ors, lat, uns, to);
        total++; if (uns !== 0) begin bad++; $display("FAIL b2b_hold_stable got=%0d exp=0", uns); end
        total++; if ({ow, ors} !== {1'b1, 2'b01}) begin bad++; $display("FAIL b2b_rsp got=%b/%b exp=1/01", ow, ors); end
        total++; if ({cmd_ready, rsp_valid} !== 2'b10) begin bad++; $display("FAIL b2b_ready_after got=%b exp=10", {cmd_ready, rsp_valid}); end
        s_rdata = 32'h0BAD_F00D; s_rresp = 2'b11;
        run_cmd(1'b0, 32'h08, 32'h0, 0, ow, ord, ors, lat, uns, to);
        total++; if ({ow, ors, ord} !== {1'b0, 2'b11, 32'h0BAD_F00D}) begin bad++; $display("FAIL b2b_second got=%b/%b/%h exp=0/11/0badf00d", ow, ors, ord); end
        s_bresp = 2'b00; s_rresp = 2'b00;
    endtask

    task automatic test_reset_mid();
        logic ow; logic [31:0] ord; logic [1:0] ors; int lat, uns, to;
        int n;
        set_slave(0, 0, 10, 0, 0);
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0C; cmd_wdata = 32'h77;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 0;
        n = 0;
        while (!m_axi_bready && n < 50) begin @(negedge clk); n++; end
        total++; if (m_axi_bready !== 1'b1) begin bad++; $display("FAIL rstmid_reach_wr_resp got=%b exp=1", m_axi_bready); end
        rst = 1;
        @(negedge clk);
        total++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid, cmd_ready} !== 7'b0000001) begin
            bad++; $display("FAIL rstmid_handshakes got=%b exp=0000001",
                {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid, cmd_ready});
        end
        total++; if ({m_axi_awaddr, m_axi_wdata} !== 64'd0) begin bad++; $display("FAIL rstmid_payload got=%h/%h exp=0", m_axi_awaddr, m_axi_wdata); end
        @(negedge clk);
        rst = 0;
        set_slave(0, 0, 0, 1, 1); s_rdata = 32'h1357_9BDF;
        run_cmd(1'b0, 32'h10, 32'h0, 0, ow, ord, ors, lat, uns, to);
        total++; if ({to, ow, ord} !== {32'd0, 1'b0, 32'h1357_9BDF}) begin bad++; $display("FAIL rstmid_recover got=%0d/%b/%h exp=0/0/13579bdf", to, ow, ord); end
    endtask

    task automatic test_random();
        logic ow; logic [31:0] ord; logic [1:0] ors; int lat, uns, to;
        logic wr; logic [31:0] addr, data, exp_rdata, got_addr; logic [1:0] exp_resp;
        int hold, exp_lat;
        for (int k = 0; k < 40; k++) begin
            wr = 1'($urandom); addr = $urandom & 32'h0000_FFFC; data = $urandom;
            set_slave(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            s_bresp = 2'($urandom); s_rresp = 2'($urandom); s_rdata = $urandom;
            hold = int'($urandom_range(0, 2));
            exp_lat   = wr ? 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly : 3 + ar_dly + r_dly;
            exp_rdata = wr ? 32'h0 : s_rdata;
            exp_resp  = wr ? s_bresp : s_rresp;
            run_cmd(wr, addr, data, hold, ow, ord, ors, lat, uns, to);
            got_addr = wr ? got_awaddr : got_araddr;
            total++; if (to !== 0) begin bad++; $display("FAIL rnd%0d_timeout got=%0d exp=0", k, to); end
            total++; if ({ow, ors, ord} !== {wr, exp_resp, exp_rdata}) begin
                bad++; $display("FAIL rnd%0d_rsp got=%b/%b/%h exp=%b/%b/%h", k, ow, ors, ord, wr, exp_resp, exp_rdata);
            end
            total++; if (lat !== exp_lat) begin bad++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", k, lat, exp_lat); end
            total++; if (got_addr !== addr) begin bad++; $display("FAIL rnd%0d_addr got=%h exp=%h", k, got_addr, addr); end
            total++; if (uns !== 0) begin bad++; $display("FAIL rnd%0d_hold_stable got=%0d exp=0", k, uns); end
            if (wr) begin
                total++; if ({got_wdata, got_wstrb} !== {data, 4'hF}) begin
                    bad++; $display("FAIL rnd%0d_wdata got=%h/%h exp=%h/f", k, got_wdata, got_wstrb, data);
                end
            end
        end
        total++; if (proto_bad !== 0) begin bad++; $display("FAIL rnd_protocol got=%0d exp=0", proto_bad); end
    endtask

    initial begin
        rst = 1; cmd_valid = 0; rsp_ready = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        test_reset();
        test_zero_wait_write();
        test_aw_stall();
        test_slverr();
        test_read_delay();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
